decodificador_rd: RTL

//   Read-side controller for the 12-entry register bank; the read

---
 rtl/decrd_pkg.sv | 30 +++
 rtl/sel_a_onehot.sv | 35 +++
 rtl/decodificador_rd.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/decrd_pkg.sv
// -----------------------------------------------------------------------------
// decrd_pkg
//   Shared definitions for the read-side controller of the register bank:
//   bank geometry, select width, the controller state encoding, the default
//   response wait limit and a select range-check helper.
//   Optional feature macro used by the controller: DECRD_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package decrd_pkg;

   // Bank geometry
   localparam int NREG_C = 12;
   localparam int SEL_W  = 4;
   localparam int DW_C   = 16;

   // Default response wait limit (cycles) when the timeout feature is built in
   localparam int TIMEOUT_C = 255;

   // Controller states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      RESP    = 2'd2
   } state_t;

   // True when a select value addresses an existing register
   function automatic logic sel_in_range(input logic [SEL_W-1:0] sel, input int nreg);
      return (int'(sel) < nreg);
   endfunction

endpackage : decrd_pkg

// File: rtl/sel_a_onehot.sv
// -----------------------------------------------------------------------------
// sel_a_onehot
//   Combinational register-select decoder. Converts a select index into a
//   one-hot strobe vector and reports whether the index addresses an existing
//   register. Out-of-range indices give an all-zero strobe; the strobe is
//   additionally forced to zero while the enable is low.
//
// Ports
//   sel       in   SEL_W   register index
//   en        in   1       strobe enable (controller is in its capture cycle)
//   onehot    out  NREG    one-hot strobe, all-zero when disabled/out of range
//   in_range  out  1       sel < NREG
// -----------------------------------------------------------------------------
module sel_a_onehot
   import decrd_pkg::*;
#(
   parameter int NREG = NREG_C
) (
   input  logic [SEL_W-1:0] sel,
   input  logic             en,
   output logic [NREG-1:0]  onehot,
   output logic             in_range
);

   // Decode the index; a bit can only match an index below NREG, so
   // out-of-range values naturally produce an all-zero vector.
   always_comb begin
      onehot   = '0;
      in_range = sel_in_range(sel, NREG);
      for (int i = 0; i < NREG; i++) begin
         onehot[i] = en & (sel == SEL_W'(i));
      end
   end

endmodule : sel_a_onehot

// File: rtl/decodificador_rd.sv
// -----------------------------------------------------------------------------
// decodificador_rd
//   Read-side controller for the register bank. A read request (sel) is taken
//   over a valid/ready handshake, a one-cycle one-hot read strobe is pulsed for
//   clear-on-read registers, and the selected register is captured and held
//   until the consumer accepts the response. Only one request is in flight.
//
//   Sequence: accept (IDLE) -> one CAPTURE cycle with strobe -> RESP until the
//   consumer takes the data, then back to IDLE.
//
//   Optional feature (macro DECRD_TIMEOUT_EN): a wait counter in RESP drops an
//   unaccepted response after TIMEOUT stalled cycles and pulses tmo. Without
//   the macro there is no counter, no tmo port and RESP waits indefinitely.
//
// Ports
//   clk         in   1         clock, rising edge
//   rst_n       in   1         asynchronous active-low reset
//   rd_valid    in   1         read request valid
//   rd_ready    out  1         controller can accept a request
//   sel         in   SEL_W     register index, sampled on accept
//   regs        in   NREG*DW   flattened bank, register i at [i*DW +: DW]
//   re          out  NREG      one-hot read strobe, one cycle wide
//   resp_valid  out  1         response valid
//   resp_ready  in   1         consumer accepts the response
//   data        out  DW        read data
//   rd_err      out  1         captured index was out of range
//   tmo         out  1         timeout pulse (DECRD_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module decodificador_rd
   import decrd_pkg::*;
#(
   parameter int DW      = DW_C,
   parameter int NREG    = NREG_C,
   parameter int TIMEOUT = TIMEOUT_C
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rd_valid,
   output logic             rd_ready,
   input  logic [SEL_W-1:0] sel,
   input  logic [NREG*DW-1:0] regs,
   output logic [NREG-1:0]  re,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [DW-1:0]    data,
   output logic             rd_err
`ifdef DECRD_TIMEOUT_EN
   ,
   output logic             tmo
`endif
);

   state_t             state_r;
   logic [SEL_W-1:0]   sel_q_r;
   logic               rd_ready_r;
   logic               resp_valid_r;
   logic [DW-1:0]      data_r;
   logic               rd_err_r;
   logic [NREG-1:0]    onehot_s;
   logic               in_range_s;
   logic               capture_s;
   logic [DW-1:0]      rd_word_s;

`ifdef DECRD_TIMEOUT_EN
   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
   logic [7:0]         wait_cnt_r;
   logic               tmo_r;
`endif

   assign capture_s = (state_r == CAPTURE);

   sel_a_onehot #(
      .NREG (NREG)
   ) u_sel_a_onehot (
      .sel      (sel_q_r),
      .en       (capture_s),
      .onehot   (onehot_s),
      .in_range (in_range_s)
   );

   // Bank read mux built as an AND-OR over all registers so an out-of-range
   // index never produces an out-of-bounds part-select; it yields zero instead.
   always_comb begin
      rd_word_s = '0;
      for (int i = 0; i < NREG; i++) begin
         rd_word_s = rd_word_s | ({DW{sel_q_r == SEL_W'(i)}} & regs[i*DW +: DW]);
      end
   end

   // Controller FSM with registered handshake and response outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         sel_q_r      <= '0;
         rd_ready_r   <= 1'b1;
         resp_valid_r <= 1'b0;
         data_r       <= '0;
         rd_err_r     <= 1'b0;
`ifdef DECRD_TIMEOUT_EN
         wait_cnt_r   <= 8'd0;
         tmo_r        <= 1'b0;
`endif
      end else begin
`ifdef DECRD_TIMEOUT_EN
         // tmo is a single-cycle pulse unless re-raised below
         tmo_r <= 1'b0;
`endif
         case (state_r)
            IDLE: begin
               if (rd_valid) begin
                  sel_q_r    <= sel;
                  rd_ready_r <= 1'b0;
                  state_r    <= CAPTURE;
               end else begin
                  rd_ready_r <= 1'b1;
               end
            end

            CAPTURE: begin
               // The strobe is live this cycle; data is taken at its end
               if (in_range_s) begin
                  data_r   <= rd_word_s;
                  rd_err_r <= 1'b0;
               end else begin
                  data_r   <= '0;
                  rd_err_r <= 1'b1;
               end
               resp_valid_r <= 1'b1;
               state_r      <= RESP;
`ifdef DECRD_TIMEOUT_EN
               wait_cnt_r   <= 8'd0;
`endif
            end

            RESP: begin
               if (resp_ready) begin
                  resp_valid_r <= 1'b0;
                  data_r       <= '0;
                  rd_err_r     <= 1'b0;
                  rd_ready_r   <= 1'b1;
                  state_r      <= IDLE;
`ifdef DECRD_TIMEOUT_EN
               end else if ((wait_cnt_r + 8'd1) == TMO_LIMIT) begin
                  // This stalled cycle is the TIMEOUT-th one: drop the response
                  tmo_r        <= 1'b1;
                  wait_cnt_r   <= wait_cnt_r + 8'd1;
                  resp_valid_r <= 1'b0;
                  data_r       <= '0;
                  rd_err_r     <= 1'b0;
                  rd_ready_r   <= 1'b1;
                  state_r      <= IDLE;
               end else begin
                  wait_cnt_r   <= wait_cnt_r + 8'd1;
`else
               end else begin
                  resp_valid_r <= 1'b1;
`endif
               end
            end

            default: begin
               resp_valid_r <= 1'b0;
               data_r       <= '0;
               rd_err_r     <= 1'b0;
               rd_ready_r   <= 1'b1;
               state_r      <= IDLE;
            end
         endcase
      end
   end

   assign rd_ready   = rd_ready_r;
   assign resp_valid = resp_valid_r;
   assign data       = data_r;
   assign rd_err     = rd_err_r;
   // Strobe comes straight from registered state and index through the decoder
   assign re         = onehot_s;
`ifdef DECRD_TIMEOUT_EN
   assign tmo        = tmo_r;
`endif

endmodule : decodificador_rd
